// File: rtl/pulse_meter_if.sv
// Measurement port of pulse_meter: one period/high-time pair offered under valid/ready.
// valid/ready: a pair moves on every edge where meas_valid & meas_ready are both 1;
// while meas_valid=1 and meas_ready=0 the producer holds meas_period/meas_high stable.
interface pulse_meter_if #(
   parameter int CNT_W = 32
);
   logic [CNT_W-1:0] meas_period;
   logic [CNT_W-1:0] meas_high;
   logic             meas_valid;
   logic             meas_ready;

   modport master (
      output meas_period,
      output meas_high,
      output meas_valid,
      input  meas_ready
   );

   modport slave (
      input  meas_period,
      input  meas_high,
      input  meas_valid,
      output meas_ready
   );
endinterface

// File: rtl/pulse_meter.sv
// Rise/fall strobes plus period and high-time measurement of a filtered level,
// with a loss-of-signal watchdog that drops lock when rising edges stop.
module pulse_meter #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clean,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic             overrun,
   output logic             locked,
   output logic             timeout_pulse,
   output logic             dbg_state,
   pulse_meter_if.master    m_if
);

   typedef enum logic {
      S_WAIT_RISE = 1'b0,
      S_RUN       = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
   localparam bit               WD_EN   = (TIMEOUT != 0);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_high_hold;
   logic             r_clean_d;
   logic             r_armed;

   logic             w_rise;
   logic             w_fall;
   logic             w_xfer;
   logic             w_room;
   logic             w_wd_hit;
   logic [CNT_W-1:0] w_cnt_inc;

   // armed masks the very first sample so a level already high at reset release is not a rise
   assign w_rise    = r_armed & clean & ~r_clean_d;
   assign w_fall    = r_armed & ~clean & r_clean_d;
   assign w_xfer    = m_if.meas_valid & m_if.meas_ready;
   assign w_room    = ~m_if.meas_valid | m_if.meas_ready;
   assign w_wd_hit  = WD_EN && (r_cnt == TO_VAL);
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
   assign dbg_state = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= S_WAIT_RISE;
         r_cnt            <= '0;
         r_high_hold      <= '0;
         r_clean_d        <= 1'b0;
         r_armed          <= 1'b0;
         rise_pulse       <= 1'b0;
         fall_pulse       <= 1'b0;
         overrun          <= 1'b0;
         locked           <= 1'b0;
         timeout_pulse    <= 1'b0;
         m_if.meas_period <= '0;
         m_if.meas_high   <= '0;
         m_if.meas_valid  <= 1'b0;
      end else begin
         r_clean_d     <= clean;
         r_armed       <= 1'b1;
         rise_pulse    <= w_rise;
         fall_pulse    <= w_fall;
         timeout_pulse <= 1'b0;

         // accepted transfer; a capture below in the same cycle overrides these
         if (w_xfer) begin
            m_if.meas_valid <= 1'b0;
            overrun         <= 1'b0;
         end

         case (r_state)
            S_WAIT_RISE: begin
               r_cnt <= '0;
               if (w_rise) begin
                  r_state <= S_RUN;
                  locked  <= 1'b1;
                  r_cnt   <= CNT_W'(1);
               end
            end

            S_RUN: begin
               if (w_fall) begin
                  r_high_hold <= r_cnt;
               end
               if (w_rise) begin
                  r_cnt <= CNT_W'(1);
                  if (w_room) begin
                     m_if.meas_period <= r_cnt;
                     m_if.meas_high   <= r_high_hold;
                     m_if.meas_valid  <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else if (w_wd_hit) begin
                  timeout_pulse <= 1'b1;
                  r_state       <= S_WAIT_RISE;
                  locked        <= 1'b0;
                  r_cnt         <= '0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            default: begin
               r_state <= S_WAIT_RISE;
               locked  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: square wave, backpressure, reset, watchdog and
// saturation, each run on an instance configured for that scenario.
module tb_pulse_meter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // instance a: CNT_W=16, no watchdog
   logic clean_a = 1'b0;
   logic rise_a, fall_a, ovr_a, lock_a, to_a, dbg_a;
   pulse_meter_if #(.CNT_W(16)) if_a ();
   pulse_meter #(.CNT_W(16), .TIMEOUT(0)) u_a (
      .clk(clk), .rst(rst), .clean(clean_a),
      .rise_pulse(rise_a), .fall_pulse(fall_a), .overrun(ovr_a),
      .locked(lock_a), .timeout_pulse(to_a), .dbg_state(dbg_a), .m_if(if_a)
   );

   // instance w: CNT_W=16, TIMEOUT=50
   logic clean_w = 1'b0;
   logic rise_w, fall_w, ovr_w, lock_w, to_w, dbg_w;
   pulse_meter_if #(.CNT_W(16)) if_w ();
   pulse_meter #(.CNT_W(16), .TIMEOUT(50)) u_w (
      .clk(clk), .rst(rst), .clean(clean_w),
      .rise_pulse(rise_w), .fall_pulse(fall_w), .overrun(ovr_w),
      .locked(lock_w), .timeout_pulse(to_w), .dbg_state(dbg_w), .m_if(if_w)
   );

   // instance s: CNT_W=4, no watchdog
   logic clean_s = 1'b0;
   logic rise_s, fall_s, ovr_s, lock_s, to_s, dbg_s;
   pulse_meter_if #(.CNT_W(4)) if_s ();
   pulse_meter #(.CNT_W(4), .TIMEOUT(0)) u_s (
      .clk(clk), .rst(rst), .clean(clean_s),
      .rise_pulse(rise_s), .fall_pulse(fall_s), .overrun(ovr_s),
      .locked(lock_s), .timeout_pulse(to_s), .dbg_state(dbg_s), .m_if(if_s)
   );

   // high time of each 10-cycle period in the square-wave run
   int hi_tab[10] = '{3, 3, 3, 3, 3, 3, 5, 3, 4, 3};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rdy_a(input int p, input int k);
      if (p == 5 || p == 6) return 1'b0;
      if (p == 7) return (k >= 4);
      if (p == 8) return (k == 0);
      return 1'b1;
   endfunction

   function automatic logic exp_valid_a(input int p, input int k);
      if (p == 0) return 1'b0;
      if (p == 5 || p == 6 || p == 8) return 1'b1;
      if (p == 7) return (k < 4);
      return (k == 0);
   endfunction

   initial begin
      if_a.meas_ready = 1'b1;
      if_w.meas_ready = 1'b1;
      if_s.meas_ready = 1'b1;

      // reset state
      step();
      step();
      check("rst_rise", rise_a, 0);
      check("rst_valid", if_a.meas_valid, 0);
      check("rst_lock", lock_a, 0);
      check("rst_ovr", ovr_a, 0);
      check("rst_period", if_a.meas_period, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("idle_lock", lock_a, 0);

      // square wave 10-cycle period with backpressure and simultaneous capture+accept
      for (int p = 0; p < 10; p++) begin
         for (int k = 0; k < 10; k++) begin
            clean_a = (k < hi_tab[p]);
            if_a.meas_ready = rdy_a(p, k);
            step();
            check("sq_rise", rise_a, (k == 0));
            check("sq_fall", fall_a, (k == hi_tab[p]));
            check("sq_lock", lock_a, 1);
            check("sq_valid", if_a.meas_valid, exp_valid_a(p, k));
            check("sq_ovr", ovr_a, ((p == 6) || (p == 7 && k < 4)));
            if (exp_valid_a(p, k)) begin
               check("sq_period", if_a.meas_period, 10);
               check("sq_high", if_a.meas_high, (p == 9) ? 4 : 3);
            end
         end
      end

      // asynchronous reset with a measurement pending
      clean_a = 1'b1;
      if_a.meas_ready = 1'b1;
      step();
      check("pre_rst_valid", if_a.meas_valid, 1);
      check("pre_rst_rise", rise_a, 1);
      rst = 1'b1;
      #1;
      check("arst_valid", if_a.meas_valid, 0);
      check("arst_rise", rise_a, 0);
      check("arst_lock", lock_a, 0);
      check("arst_period", if_a.meas_period, 0);
      check("arst_high", if_a.meas_high, 0);
      check("arst_ovr", ovr_a, 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("hi_rel_rise", rise_a, 0);
         check("hi_rel_lock", lock_a, 0);
      end
      clean_a = 1'b0;
      step();
      clean_a = 1'b1;
      step();
      check("relock_rise", rise_a, 1);
      check("relock_lock", lock_a, 1);
      check("relock_valid", if_a.meas_valid, 0);

      // watchdog: one rise then stuck low
      clean_w = 1'b1;
      step();
      check("wd_rise", rise_w, 1);
      check("wd_lock0", lock_w, 1);
      for (int i = 1; i <= 60; i++) begin
         clean_w = 1'b0;
         step();
         check("wd_pulse", to_w, (i == 50));
         check("wd_lock", lock_w, (i < 50));
      end
      clean_w = 1'b1;
      step();
      check("wd_re_lock", lock_w, 1);
      check("wd_re_valid", if_w.meas_valid, 0);
      for (int i = 1; i < 8; i++) begin
         clean_w = (i < 2);
         step();
      end
      clean_w = 1'b1;
      step();
      check("wd_m_valid", if_w.meas_valid, 1);
      check("wd_m_period", if_w.meas_period, 8);
      check("wd_m_high", if_w.meas_high, 2);

      // rise lands on the cycle the counter reaches TIMEOUT
      for (int i = 1; i < 50; i++) begin
         clean_w = (i < 2);
         step();
         check("tie_no_to", to_w, 0);
      end
      clean_w = 1'b1;
      step();
      check("tie_to", to_w, 0);
      check("tie_valid", if_w.meas_valid, 1);
      check("tie_period", if_w.meas_period, 50);
      check("tie_high", if_w.meas_high, 2);
      check("tie_lock", lock_w, 1);
      step();
      check("tie_to_next", to_w, 0);
      check("tie_lock_next", lock_w, 1);

      // saturation with CNT_W=4: period 20, high 17
      clean_s = 1'b1;
      step();
      check("sat_lock", lock_s, 1);
      check("sat_valid0", if_s.meas_valid, 0);
      for (int i = 1; i < 20; i++) begin
         clean_s = (i < 17);
         step();
      end
      clean_s = 1'b1;
      step();
      check("sat_valid", if_s.meas_valid, 1);
      check("sat_period", if_s.meas_period, 15);
      check("sat_high", if_s.meas_high, 15);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pulse_meter.md
# pulse_meter

Edge and period measurement stage that sits directly downstream of the antiglitch filter. It consumes the filtered level `clean`, emits single-cycle rise and fall strobes, and measures the period between consecutive rising edges and the high time within each period, in clock cycles. Each completed measurement is offered on a valid/ready port. A loss-of-signal watchdog drops lock when edges stop arriving.

## Interface
- `CNT_W`, 32: width of the period and high-time counters and outputs, ≥ 2.
- `TIMEOUT`, 0: cycles without a rising edge before lock is dropped. 0 disables the watchdog. Must be < 2^CNT_W.

- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `clean`  in  1  filtered level from antiglitch, synchronous to `clk`.
- `rise_pulse`  out  1  one-cycle strobe on a detected rising edge.
- `fall_pulse`  out  1  one-cycle strobe on a detected falling edge.
- `meas_period`  out  CNT_W  cycles between the last two rising edges.
- `meas_high`  out  CNT_W  cycles from a rising edge to the following falling edge.
- `meas_valid`  out  1  measurement pair available.
- `meas_ready`  in  1  consumer accepts the measurement.
- `overrun`  out  1  sticky; a measurement was dropped.
- `locked`  out  1  FSM is in RUN.
- `timeout_pulse`  out  1  one-cycle strobe when the watchdog fires.

## Operation
- Edge detect uses `clean_d`, `clean` registered once.
  - A rise is `clean & ~clean_d`; a fall is `~clean & clean_d`.
  - An `armed` flag is 0 after reset and sets on the first clock edge. Edges are not detected while `armed` = 0, so an input already high at reset release produces no rise.
- FSM states:
  - WAIT_RISE (reset state): `cnt` is held at 0. On a rise: go to RUN, set `cnt` ← 1, emit nothing on the measurement port.
  - RUN, each cycle:
    - On a rise: capture `meas_period` ← `cnt` and `meas_high` ← `high_hold`, then `cnt` ← 1.
    - Otherwise: `cnt` ← `cnt`+1, saturating at 2^CNT_W−1.
    - On a fall: `high_hold` ← `cnt` (value before increment).
    - Watchdog: if TIMEOUT ≠ 0 and `cnt` = TIMEOUT with no rise this cycle, pulse `timeout_pulse`, go to WAIT_RISE, set `cnt` ← 0.
  - Rise and watchdog in the same cycle: the rise wins and no timeout occurs.
- Count semantics:
  - Rises sampled at edges t0 and t1 give `meas_period` = t1−t0.
  - A fall at tf gives high time tf−t0.
  - Saturated values are reported as 2^CNT_W−1.
- Measurement port:
  - A capture with `meas_valid`=0, or with `meas_valid`&`meas_ready` in the same cycle, loads the data and sets `meas_valid`=1.
  - A capture with `meas_valid`=1 and `meas_ready`=0 drops the new data, keeps the old data and sets `overrun`=1.
  - `meas_valid`&`meas_ready` with no capture clears `meas_valid`.
  - `overrun` clears on any accepted transfer (`meas_valid`&`meas_ready`), unless a drop happens in that same cycle.
  - Data is stable while `meas_valid`=1 and `meas_ready`=0.
- `locked` = (state == RUN).

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state WAIT_RISE, `cnt`, `high_hold`, `clean_d` and `armed` all 0.
- `rst` asserted mid-operation clears everything immediately (asynchronous). A pending measurement is lost, and `overrun` is not set.
- Latency: if `clean` is first sampled high at edge E, then `rise_pulse`, `meas_valid`/data and `locked` (from WAIT_RISE) update at E and are visible until E+1.
  - `fall_pulse` has the same latency.
- `meas_valid` falls at the edge where `meas_valid`&`meas_ready` is sampled, with no new capture.
- The watchdog fires at the edge where `cnt` = TIMEOUT is sampled. That is TIMEOUT cycles after the last rise.
- Back-to-back captures are possible every 2 cycles (minimum period 2).

## Test plan
- Square wave (CNT_W=16, TIMEOUT=0), high 3 / low 7 cycles, `meas_ready`=1.
  - Required: the first rise gives `locked`=1 and no `meas_valid`.
  - Every later rise gives a 1-cycle `meas_valid` with `meas_period`=10, `meas_high`=3.
  - `rise_pulse` and `fall_pulse` are each one cycle wide.
- Backpressure, same wave, `meas_ready`=0 for 3 periods, then 1.
  - Required: the first measurement is held unchanged and `overrun`=1 after the second capture.
  - On `meas_ready`=1 the data is accepted, then `overrun`=0 and `meas_valid`=0.
- Watchdog (TIMEOUT=50): one rise, then `clean` stuck low.
  - Required: `timeout_pulse` 50 cycles after the rise, then `locked`=0.
  - The next rise gives no measurement. The rise after it gives a correct period.
- Reset with `clean`=1 held high, `rst` released.
  - Required: no `rise_pulse` and `locked`=0 until `clean` goes 0→1.
  - `rst` pulsed mid-period with `meas_valid`=1 forces all outputs to 0 immediately.
- Saturation (CNT_W=4, TIMEOUT=0), period 20, high 17.
  - Required: `meas_period`=15, `meas_high`=15.
- Simultaneous events: capture coincides with `meas_valid`&`meas_ready`.
  - Required: new data loaded, `meas_valid` stays 1, no `overrun`.
  - Rise in the same cycle that `cnt` reaches TIMEOUT: no `timeout_pulse`, measurement emitted.
